// File: rtl/mac_feeder.sv
// Operand sequencer for the MAC tile: buffers g/e operand streams, issues whole
// LEN-pair vectors back to back, and holds each vector's final MAC output in a result slot.
module mac_feeder #(
  parameter int unsigned N     = 8,
  parameter int unsigned LEN   = 4,
  parameter int unsigned DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         g_valid,
  output logic         g_ready,
  input  logic [N-1:0] g_data,
  input  logic         e_valid,
  output logic         e_ready,
  input  logic [N-1:0] e_data,
  output logic [N-1:0] mac_g,
  output logic [N-1:0] mac_e,
  output logic         mac_clr,
  input  logic [N-1:0] mac_o,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [N-1:0] res_data,
  output logic         busy
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned IW = (LEN > 1) ? $clog2(LEN) : 1;

  localparam logic [CW-1:0] LenC    = CW'(LEN);
  localparam logic [CW-1:0] DepthC  = CW'(DEPTH);
  localparam logic [AW-1:0] PtrLast = AW'(DEPTH - 1);
  localparam logic [IW-1:0] IdxLast = IW'(LEN - 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StClr  = 2'd1;
  localparam logic [1:0] StRun  = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          mac_clr_q;

  logic [N-1:0]  g_mem [DEPTH];
  logic [N-1:0]  e_mem [DEPTH];
  logic [AW-1:0] g_wptr_q, g_rptr_q, e_wptr_q, e_rptr_q;
  logic [CW-1:0] g_count_q, e_count_q;

  logic g_push, e_push, pop, start, last;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == PtrLast) ? '0 : p + AW'(1);
  endfunction

  assign g_ready = (g_count_q < DepthC);
  assign e_ready = (e_count_q < DepthC);
  assign g_push  = g_valid && g_ready;
  assign e_push  = e_valid && e_ready;
  assign pop     = (state_q == StRun);
  assign last    = pop && (idx_q == IdxLast);
  // Only start once a full vector is buffered: the MAC cannot be stalled mid-vector.
  assign start   = (g_count_q >= LenC) && (e_count_q >= LenC) && (!res_valid || res_ready);

  always_ff @(posedge clk) begin
    if (g_push) g_mem[g_wptr_q] <= g_data;
    if (e_push) e_mem[e_wptr_q] <= e_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      g_wptr_q  <= '0;
      g_rptr_q  <= '0;
      g_count_q <= '0;
      e_wptr_q  <= '0;
      e_rptr_q  <= '0;
      e_count_q <= '0;
    end else begin
      if (g_push) g_wptr_q <= next_ptr(g_wptr_q);
      if (e_push) e_wptr_q <= next_ptr(e_wptr_q);
      if (pop) begin
        g_rptr_q <= next_ptr(g_rptr_q);
        e_rptr_q <= next_ptr(e_rptr_q);
      end
      g_count_q <= g_count_q + CW'(g_push) - CW'(pop);
      e_count_q <= e_count_q + CW'(e_push) - CW'(pop);
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      StIdle: if (start) state_d = StClr;
      StClr: begin
        state_d = StRun;
        idx_d   = '0;
      end
      StRun: begin
        idx_d = idx_q + IW'(1);
        if (last) begin
          state_d = StIdle;
          idx_d   = '0;
        end
      end
      default: begin
        state_d = StIdle;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      mac_clr_q <= 1'b1;
      res_valid <= 1'b0;
      res_data  <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      // Registered from next state so the clear drops exactly on the first RUN cycle.
      mac_clr_q <= (state_d != StRun);
      if (last) begin
        res_valid <= 1'b1;
        res_data  <= mac_o;
      end else if (res_valid && res_ready) begin
        res_valid <= 1'b0;
      end
    end
  end

  assign mac_clr = mac_clr_q;
  assign mac_g   = pop ? g_mem[g_rptr_q] : '0;
  assign mac_e   = pop ? e_mem[e_rptr_q] : '0;
  assign busy    = (state_q != StIdle);

endmodule

// File: tb/tb_mac_feeder.sv
// Directed bench for mac_feeder with an XOR stand-in for the MAC tile.
module tb_mac_feeder;

  logic       clk, rst;
  logic       g_valid, g_ready, e_valid, e_ready;
  logic [7:0] g_data, e_data, mac_g, mac_e, mac_o, res_data;
  logic       mac_clr, res_valid, res_ready, busy;

  int n_checks = 0;
  int n_pass   = 0;
  int ni, nres;
  logic acc;
  logic [7:0] exp_res [3];

  assign mac_o = mac_g ^ mac_e;

  mac_feeder #(.N(8), .LEN(4), .DEPTH(8)) dut (
    .clk(clk), .rst(rst),
    .g_valid(g_valid), .g_ready(g_ready), .g_data(g_data),
    .e_valid(e_valid), .e_ready(e_ready), .e_data(e_data),
    .mac_g(mac_g), .mac_e(mac_e), .mac_clr(mac_clr), .mac_o(mac_o),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0; g_valid = 0; e_valid = 0; g_data = 0; e_data = 0; res_ready = 0;
    exp_res[0] = 8'h7f; exp_res[1] = 8'h7b; exp_res[2] = 8'h77;
    tick; tick;
    check("rst_g_ready", g_ready, 1);
    check("rst_e_ready", e_ready, 1);
    check("rst_mac_clr", mac_clr, 1);
    check("rst_mac_g", mac_g, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_data", res_data, 0);
    check("rst_busy", busy, 0);
    rst = 1'b1;
    tick;

    // Basic vector: g=1..4, e=1 -> 4^1 = 5
    for (int k = 1; k <= 4; k++) begin
      g_valid = 1; e_valid = 1; g_data = 8'(k); e_data = 8'h01;
      tick;
    end
    g_valid = 0; e_valid = 0;
    check("t1_idle_busy", busy, 0);
    check("t1_idle_clr", mac_clr, 1);
    tick;
    check("t1_clr_busy", busy, 1);
    check("t1_clr_clr", mac_clr, 1);
    check("t1_clr_mac_g", mac_g, 0);
    for (int k = 1; k <= 4; k++) begin
      tick;
      check("t1_run_clr", mac_clr, 0);
      check("t1_run_mac_g", mac_g, k);
      check("t1_run_mac_e", mac_e, 1);
      check("t1_run_no_res", res_valid, 0);
    end
    tick;
    check("t1_res_valid", res_valid, 1);
    check("t1_res_data", res_data, 8'h05);
    check("t1_after_clr", mac_clr, 1);
    check("t1_after_busy", busy, 0);
    res_ready = 1;
    tick;
    check("t1_drained", res_valid, 0);
    res_ready = 0;

    // Unbalanced streams: 4 g, 3 e must not start
    for (int k = 0; k < 4; k++) begin
      g_valid = 1; g_data = 8'(10 + k);
      e_valid = (k < 3); e_data = 8'(20 + k);
      tick;
    end
    g_valid = 0; e_valid = 0;
    tick; tick;
    check("t2_wait_busy", busy, 0);
    check("t2_wait_clr", mac_clr, 1);
    check("t2_wait_mac_g", mac_g, 0);
    check("t2_wait_mac_e", mac_e, 0);
    e_valid = 1; e_data = 8'd23;
    tick;
    e_valid = 0;
    check("t2_idle", busy, 0);
    tick;
    check("t2_started", busy, 1);
    for (int k = 0; k < 4; k++) begin
      tick;
      check("t2_run_mac_g", mac_g, 10 + k);
      check("t2_run_mac_e", mac_e, 20 + k);
    end
    tick;
    check("t2_res_data", res_data, 8'h1a);
    res_ready = 1;
    tick;
    res_ready = 0;

    // Fill to DEPTH under result backpressure
    for (int k = 0; k < 12; k++) begin
      g_valid = 1; e_valid = 1; g_data = 8'(8'h30 + k); e_data = 8'(8'h40 + k);
      tick;
    end
    g_valid = 0; e_valid = 0;
    check("t3_g_full", g_ready, 0);
    check("t3_e_full", e_ready, 0);
    check("t3_res_valid", res_valid, 1);
    check("t3_res_data", res_data, 8'h70);
    tick; tick;
    check("t3_blocked", busy, 0);
    check("t3_held", res_data, 8'h70);
    res_ready = 1;
    tick;
    res_ready = 0;
    check("t3_drain", res_valid, 0);
    check("t3_clr_state", busy, 1);
    check("t3_clr_full", g_ready, 0);
    g_valid = 1; e_valid = 1; g_data = 8'h50; e_data = 8'h60;
    tick;
    check("t3_run1_mac_g", mac_g, 8'h34);
    check("t3_run1_full", g_ready, 0);
    tick;
    check("t3_run2_mac_g", mac_g, 8'h35);
    check("t3_run2_ready", g_ready, 1);
    tick;
    g_data = 8'h51; e_data = 8'h61;
    check("t3_run3_mac_g", mac_g, 8'h36);
    tick;
    g_data = 8'h52; e_data = 8'h62;
    check("t3_run4_mac_g", mac_g, 8'h37);
    tick;
    g_valid = 0; e_valid = 0;
    check("t3_res2", res_data, 8'h70);
    check("t3_count7", e_ready, 1);
    res_ready = 1;
    tick;
    check("t3_drain2", res_valid, 0);
    for (int k = 0; k < 4; k++) begin
      tick;
      check("t3_v3_mac_g", mac_g, 8'h38 + k);
      check("t3_v3_mac_e", mac_e, 8'h48 + k);
    end
    tick;
    check("t3_res3", res_data, 8'h70);
    tick;
    check("t3_leftover_idle", busy, 0);
    check("t3_res3_gone", res_valid, 0);

    // Streaming with res_ready held high
    ni = 0; nres = 0;
    for (int i = 0; i < 19; i++) begin
      g_valid = 1; e_valid = 1; g_data = 8'(8'h70 + ni); e_data = 8'h0f;
      acc = g_ready;
      tick;
      if (acc) ni++;
      if (res_valid) begin
        check("t4_spacing", i, 6 * (nres + 1));
        if (nres < 3) check("t4_res_data", res_data, exp_res[nres]);
        nres++;
      end
    end
    g_valid = 0; e_valid = 0;
    check("t4_nres", nres, 3);
    tick; tick; tick;
    check("t5_pre_busy", busy, 1);
    check("t5_pre_clr", mac_clr, 0);

    // Asynchronous reset in the 2nd RUN cycle
    #2 rst = 1'b0;
    #1;
    check("t5_rst_clr", mac_clr, 1);
    check("t5_rst_mac_g", mac_g, 0);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_res_data", res_data, 0);
    check("t5_rst_g_ready", g_ready, 1);
    tick;
    rst = 1'b1;
    for (int k = 0; k < 8; k++) tick;
    check("t5_no_res", res_valid, 0);
    check("t5_no_busy", busy, 0);
    for (int k = 1; k <= 4; k++) begin
      g_valid = 1; e_valid = 1; g_data = 8'(8'h80 + k); e_data = 8'h01;
      tick;
    end
    g_valid = 0; e_valid = 0;
    for (int k = 0; k < 5; k++) tick;
    check("t5_not_yet", res_valid, 0);
    tick;
    check("t5_res_valid", res_valid, 1);
    check("t5_res_data", res_data, 8'h85);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mac_feeder.md
# mac_feeder

Operand sequencer that sits directly upstream of the MAC tile. It buffers two independent operand streams (garbler-side `g` and evaluator-side `e`) and issues exactly LEN operand pairs to the MAC on consecutive cycles. It clears the MAC accumulator before each vector and captures the final MAC output into a valid/ready result register. The MAC tile has no enable and accumulates every clock, so this block never issues a vector until the whole vector is buffered; the issue phase therefore never stalls.

## Interface
- N, 8, operand/result width
- LEN, 4, pairs per vector (dot-product length), ≥1
- DEPTH, 8, entries per operand FIFO, power of 2, ≥LEN
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset (low = reset)
- g_valid  in  1  g operand offered
- g_ready  out  1  g FIFO can accept
- g_data  in  N  g operand
- e_valid  in  1  e operand offered
- e_ready  out  1  e FIFO can accept
- e_data  in  N  e operand
- mac_g  out  N  to MAC g_input
- mac_e  out  N  to MAC e_input
- mac_clr  out  1  to MAC accumulator reset (active-high)
- mac_o  in  N  MAC combinational output o
- res_valid  out  1  result held
- res_ready  in  1  result consumer ready
- res_data  out  N  captured vector result
- busy  out  1  high in CLR or RUN

## Operation
- Two FIFOs, identical: push on valid&&ready; ready = (count < DEPTH); pop only in RUN; push and pop in the same cycle leaves count unchanged; pointers wrap modulo DEPTH; occupancy counters are log2(DEPTH)+1 bits.
- The g and e FIFOs fill independently; pairing is by order only.
- FSM states: IDLE, CLR, RUN.
  - IDLE→CLR when g_count≥LEN && e_count≥LEN && (!res_valid || res_ready).
  - CLR→RUN unconditionally after 1 cycle.
  - RUN lasts exactly LEN cycles (index counter 0..LEN-1), then →IDLE.
- mac_clr = 1 in IDLE and CLR and 0 in RUN. It is a registered output (glitch-free), so the MAC accumulator is 0 at the start of the first RUN cycle.
- In RUN, mac_g and mac_e are the FIFO heads, and one entry is popped from each FIFO per cycle. Outside RUN, mac_g and mac_e are 0.
- On the edge ending the last RUN cycle (index LEN-1): res_data ← mac_o and res_valid ← 1.
- Result register: res_valid clears on res_valid&&res_ready. It holds res_data stable while res_valid&&!res_ready. Capture cannot collide with an unconsumed result because the start condition requires the slot to be free.
- No arithmetic is performed here; widths pass through unchanged.

## Timing
- Reset values (rst low, asynchronous):
  - FIFOs empty, g_ready = e_ready = 1 (DEPTH>0).
  - State IDLE, index 0.
  - mac_clr = 1, mac_g = mac_e = 0.
  - res_valid = 0, res_data = 0, busy = 0.
- Reset asserted mid-RUN aborts the vector: all buffered operands are discarded, and no partial result is produced.
- Latency: when the LEN-th pair (both streams) is written at edge t, CLR occupies cycle t+1, RUN occupies cycles t+2..t+1+LEN, and res_valid=1 from cycle t+2+LEN.
- Back-to-back vectors: if the next vector is buffered and the result slot is free, IDLE lasts 1 cycle. The throughput is 1 vector per LEN+2 cycles.
- Backpressure: while res_valid && !res_ready, the FSM stays in IDLE. The FIFOs keep accepting until full; then ready=0.
- Full FIFO with simultaneous pop in RUN: ready stays 0 that cycle. ready is based on registered count, not lookahead.
- Pops during RUN always hit non-empty FIFOs, guaranteed by the start condition.

## Test plan
- Bench stub: mac_o = mac_g ^ mac_e. LEN=4, push g=1,2,3,4 and e=1,1,1,1 → mac_clr is low for exactly 4 cycles, mac_g = 1,2,3,4 on consecutive cycles, and res_data = 5 with res_valid asserted 6 cycles after the final push.
- Push 4 g entries but only 3 e entries → FSM stays in IDLE, mac_clr=1, mac_g=mac_e=0. Pushing the 4th e entry starts the vector on the next cycle.
- Fill both FIFOs to DEPTH=8 with res_ready=0 → g_ready=e_ready=0. After the first vector, res_valid=1 and the second vector does not start. Raising res_ready for 1 cycle drains the result, and the second vector starts in the next cycle.
- Streaming 3 vectors with res_ready=1 held and inputs always valid → vectors are spaced LEN+2=6 cycles apart, and results match the stub on each vector's 4th pair.
- Assert rst low during the 2nd RUN cycle → outputs take their reset values immediately (asynchronously). After release, no res_valid appears until 4 new pairs are pushed.
- Simultaneous push and pop while the FIFO holds 8 entries in RUN → count stays consistent. Write/read pointers wrap past 7→0 with data order preserved.
